// File: rtl/stream_muxn.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// The channel select is locked for the whole packet so packets never interleave.
module stream_muxn #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               locked
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   lock_sel_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               locked_r;

    logic [SEL_W-1:0]   active_sel_s;
    logic               can_load_s;
    logic [N-1:0]       ready_s;
    logic [WIDTH-1:0]   mux_data_s;
    logic               mux_last_s;
    logic               accept_s;

    // Channel steering, per-channel ready and accept detection.
    // An out-of-range select matches no channel, so nothing is ready.
    always_comb begin
        active_sel_s = (state_r == ST_LOCKED) ? lock_sel_r : sel;
        can_load_s   = !out_valid_r || out_ready;
        ready_s      = '0;
        mux_data_s   = '0;
        mux_last_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (SEL_W'(k) == active_sel_s) begin
                ready_s[k] = can_load_s && !rst;
                mux_data_s = in_data[k*WIDTH +: WIDTH];
                mux_last_s = in_last[k];
            end else begin
                ready_s[k] = 1'b0;
            end
        end
        accept_s = |(in_valid & ready_s);
    end

    // Output register and packet-lock FSM; locked is updated with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lock_sel_r  <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                out_data_r  <= mux_data_s;
                out_last_r  <= mux_last_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !mux_last_s) begin
                        state_r    <= ST_LOCKED;
                        lock_sel_r <= active_sel_s;
                        locked_r   <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        locked_r   <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (accept_s && mux_last_s) begin
                        state_r  <= ST_IDLE;
                        locked_r <= 1'b0;
                    end else begin
                        state_r  <= ST_LOCKED;
                        locked_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_stream_muxn.sv
// Bench for stream_muxn: directed boundary tests followed by randomized packets
// checked through an expected-beat queue drained by an independent output monitor.
module tb_stream_muxn;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [1:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic           locked;

    logic [1:0]     sel3;
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_last3;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic           out_last3;
    logic           out_ready3;
    logic           locked3;

    stream_muxn #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .locked(locked)
    );

    stream_muxn #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
        .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_last(out_last3), .out_ready(out_ready3),
        .locked(locked3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];
    logic drv_done = 1'b0;
    logic abort    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Random packets: the bench owns the schedule, so the expected output is
    // simply every issued beat in issue order.
    task automatic driver();
        int sent[N];
        int pkt = 0;
        for (int k = 0; k < N; k++) sent[k] = 0;
        while (!abort && (sent[0] < 200 || sent[1] < 200 || sent[2] < 200 || sent[3] < 200)) begin
            int c;
            int len;
            do c = $urandom_range(0, N-1); while (sent[c] >= 200);
            len = $urandom_range(1, 4);
            for (int i = 0; i < len && !abort; i++) begin
                logic [W-1:0] beat;
                logic         lst;
                bit           accepted = 1'b0;
                int           w = 0;
                beat = {8'(c), 8'(i), 16'(pkt), 32'($urandom)};
                lst  = (i == len - 1);
                sel  = (i == 0) ? 2'(c) : 2'($urandom_range(0, N-1));
                for (int k = 0; k < N; k++) begin
                    if (k != c) begin
                        in_valid[k]         = 1'($urandom_range(0, 1));
                        in_last[k]          = 1'($urandom_range(0, 1));
                        in_data[k*W +: W]   = {$urandom, $urandom};
                    end
                end
                in_data[c*W +: W] = beat;
                in_last[c]        = lst;
                in_valid[c]       = 1'b1;
                exp_q.push_back({lst, beat});
                while (!accepted && !abort) begin
                    settle();
                    chk("ready_other_ch", 64'(in_ready & ~(4'b0001 << c)), 64'd0);
                    chk("locked_in_pkt", 64'(locked), 64'(i > 0));
                    if (in_ready[c]) begin
                        accepted = 1'b1;
                    end else if (w >= 64) begin
                        checks++;
                        errors++;
                        $display("FAIL accept_timeout ch=%0d actual=not_accepted required=accepted", c);
                        abort = 1'b1;
                    end
                    w++;
                    step();
                    if (!accepted) begin
                        if (i > 0) sel = 2'($urandom_range(0, N-1));
                        for (int k = 0; k < N; k++) begin
                            if (k != c) begin
                                in_valid[k]       = 1'($urandom_range(0, 1));
                                in_data[k*W +: W] = {$urandom, $urandom};
                            end
                        end
                    end
                end
                sent[c]++;
            end
            in_valid = '0;
            pkt++;
            repeat ($urandom_range(0, 2)) step();
        end
        drv_done = 1'b1;
    endtask

    // Output side: pops one expected beat per handshake and applies random backpressure.
    task automatic monitor();
        logic [W:0]   e;
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_data  = '0;
        int           guard      = 0;
        while (!(drv_done && exp_q.size() == 0) && guard < 20000) begin
            settle();
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e[W-1:0]);
                    chk("sb_last", 64'(out_last), 64'(e[W]));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end
        if (guard >= 20000) begin
            checks++;
            errors++;
            $display("FAIL monitor_timeout actual=%0d required=0 pending", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; sel = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        sel3 = '0; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;

        // Reset with every channel valid
        in_valid = 4'hF;
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        settle(); chk("rst_in_ready", 64'(in_ready), 64'd0);
        step();   settle(); chk("rst_in_ready", 64'(in_ready), 64'd0);
        step();   settle();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        step(); rst = 1'b0; in_valid = '0; in_data = '0;

        // Single-beat packet on channel 2
        step(); sel = 2'd2; in_valid = 4'b0100; in_data[2*W +: W] = 64'hA5A5; in_last = 4'b0100;
        settle(); chk("single_ready", 64'(in_ready), 64'h4);
        step(); in_valid = '0; in_last = '0;
        settle();
        chk("single_data", out_data, 64'hA5A5);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_last", 64'(out_last), 64'd1);
        chk("single_locked", 64'(locked), 64'd0);

        // Packet lock on channel 1 while channel 0 waits and sel moves to 0
        step(); sel = 2'd1; in_valid = 4'b0011;
        in_data[1*W +: W] = 64'd1; in_last = 4'b0001; in_data[0 +: W] = 64'h100;
        settle(); chk("lock_ready0", 64'(in_ready), 64'h2); chk("lock_pre", 64'(locked), 64'd0);
        step(); sel = 2'd0; in_data[1*W +: W] = 64'd2;
        settle(); chk("lock_b1", out_data, 64'd1); chk("lock_l1", 64'(locked), 64'd1);
        chk("lock_ready1", 64'(in_ready), 64'h2);
        step(); in_data[1*W +: W] = 64'd3; in_last = 4'b0011;
        settle(); chk("lock_b2", out_data, 64'd2); chk("lock_l2", 64'(locked), 64'd1);
        step(); in_valid = 4'b0001;
        settle(); chk("lock_b3", out_data, 64'd3); chk("lock_b3_last", 64'(out_last), 64'd1);
        chk("lock_l3", 64'(locked), 64'd0); chk("lock_ready_ch0", 64'(in_ready), 64'h1);
        step(); in_valid = '0; in_last = '0;
        settle(); chk("lock_ch0_data", out_data, 64'h100); chk("lock_ch0_valid", 64'(out_valid), 64'd1);

        // Backpressure mid-packet on channel 3
        step(); sel = 2'd3; in_valid = 4'b1000; in_data[3*W +: W] = 64'h31; in_last = '0;
        settle(); chk("bp_ready", 64'(in_ready), 64'h8);
        step(); in_data[3*W +: W] = 64'h32;
        settle(); chk("bp_b1", out_data, 64'h31);
        step(); in_data[3*W +: W] = 64'h33; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_hold_data", out_data, 64'h32);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            if (i < 3) step();
        end
        step(); out_ready = 1'b1;
        settle(); chk("bp_resume_ready", 64'(in_ready), 64'h8); chk("bp_resume_data", out_data, 64'h32);
        step(); in_data[3*W +: W] = 64'h34; in_last = 4'b1000;
        settle(); chk("bp_b3", out_data, 64'h33);
        step(); in_valid = '0; in_last = '0;
        settle(); chk("bp_b4", out_data, 64'h34); chk("bp_b4_last", 64'(out_last), 64'd1);
        chk("bp_unlocked", 64'(locked), 64'd0);
        step();
        settle(); chk("bp_drained", 64'(out_valid), 64'd0);

        // Out-of-range select on a 3-channel instance
        step(); sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111;
        in_data3 = {64'hC2, 64'hC1, 64'hC0};
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("oor_ready", 64'(in_ready3), 64'd0);
            chk("oor_valid", 64'(out_valid3), 64'd0);
            step();
        end
        sel3 = 2'd2;
        settle(); chk("n3_ready", 64'(in_ready3), 64'h4);
        step(); in_valid3 = '0;
        settle(); chk("n3_valid", 64'(out_valid3), 64'd1); chk("n3_data", out_data3, 64'hC2);

        // Reset in the middle of a 4-beat packet with a beat held at the output
        step(); sel = 2'd0; in_valid = 4'b0001; in_data[0 +: W] = 64'h61; in_last = '0;
        step(); in_data[0 +: W] = 64'h62;
        settle(); chk("mid_locked", 64'(locked), 64'd1);
        step(); rst = 1'b1; in_data[0 +: W] = 64'h63;
        settle(); chk("mid_held_valid", 64'(out_valid), 64'd1); chk("mid_held_data", out_data, 64'h62);
        step(); rst = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[2*W +: W] = 64'h71; in_last = 4'b0100;
        settle();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_locked", 64'(locked), 64'd0);
        chk("mid_new_ready", 64'(in_ready), 64'h4);
        step(); in_valid = '0; in_last = '0;
        settle(); chk("mid_new_data", out_data, 64'h71); chk("mid_new_valid", 64'(out_valid), 64'd1);
        step(); sel = '0;

        fork
            driver();
            monitor();
        join
        chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
